row_accumulator: RTL and testbench

Downstream consumer of the multiplier channel's product FIFO in the sparse matrix-vector datapath. Pops one row length from the row-length FIFO, then pops exactly that many products from the product FIFO. Sums them into a wide accumulator and writes one result per row, tagged with its row index, into the result FIFO. Rows are processed strictly in order, one at a time.

---
 rtl/row_accumulator_if.sv | 30 +++
 rtl/row_accumulator.sv | 113 +++++++++++
 tb/tb_row_accumulator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/row_accumulator_if.sv
// Handshake bundle between the row accumulator and its product, row-length and result FIFOs.
// master is the accumulator side; slave is the FIFO/environment side.
interface row_accumulator_if #(
    parameter int unsigned MULT_BITS = 32,
    parameter int unsigned ACC_BITS  = 40,
    parameter int unsigned LEN_BITS  = 16,
    parameter int unsigned ROW_BITS  = 16
);
    logic [MULT_BITS-1:0] mult_out;
    logic                 mult_empty;
    logic                 mult_rd_en;
    logic [LEN_BITS-1:0]  row_len;
    logic                 row_len_empty;
    logic                 row_len_rd_en;
    logic [ACC_BITS-1:0]  res_out;
    logic [ROW_BITS-1:0]  res_row;
    logic                 res_wr_en;
    logic                 res_full;
    logic                 busy;

    modport master (
        input  mult_out, mult_empty, row_len, row_len_empty, res_full,
        output mult_rd_en, row_len_rd_en, res_out, res_row, res_wr_en, busy
    );

    modport slave (
        output mult_out, mult_empty, row_len, row_len_empty, res_full,
        input  mult_rd_en, row_len_rd_en, res_out, res_row, res_wr_en, busy
    );
endinterface

// File: rtl/row_accumulator.sv
// Sums one row of products per row-length word and pushes the tagged row sum to the result FIFO.
// Rows are handled strictly one at a time; all FIFOs are registered-read.
module row_accumulator #(
    parameter int unsigned MULT_BITS = 32,
    parameter int unsigned ACC_BITS  = 40,
    parameter int unsigned LEN_BITS  = 16,
    parameter int unsigned ROW_BITS  = 16
) (
    input logic               clk,
    input logic               rst,
    row_accumulator_if.master bus
);
    typedef enum logic [1:0] {
        StLenReq,
        StLenWait,
        StAccum,
        StEmit
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [ACC_BITS-1:0] res_out_q, res_out_d;
    logic [LEN_BITS-1:0] issue_cnt_q, issue_cnt_d;
    logic [LEN_BITS-1:0] recv_cnt_q, recv_cnt_d;
    logic [ROW_BITS-1:0] row_idx_q, row_idx_d;
    logic                valid_q;
    logic                mult_pop, len_pop, res_push;
    logic [ACC_BITS-1:0] acc_sum;

    assign acc_sum = acc_q + ACC_BITS'(bus.mult_out);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        res_out_d   = res_out_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        row_idx_d   = row_idx_q;
        mult_pop    = 1'b0;
        len_pop     = 1'b0;
        res_push    = 1'b0;
        unique case (state_q)
            StLenReq: begin
                len_pop = !bus.row_len_empty;
                if (len_pop) begin
                    acc_d   = '0;
                    state_d = StLenWait;
                end
            end
            StLenWait: begin
                issue_cnt_d = bus.row_len;
                recv_cnt_d  = bus.row_len;
                if (bus.row_len == '0) begin
                    res_out_d = '0;
                    state_d   = StEmit;
                end else begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                // Issue and receive are tracked separately so pops can run ahead of the data.
                mult_pop = !bus.mult_empty && (issue_cnt_q != '0);
                if (mult_pop) begin
                    issue_cnt_d = issue_cnt_q - LEN_BITS'(1);
                end
                if (valid_q) begin
                    acc_d      = acc_sum;
                    recv_cnt_d = recv_cnt_q - LEN_BITS'(1);
                    if (recv_cnt_q == LEN_BITS'(1)) begin
                        res_out_d = acc_sum;
                        state_d   = StEmit;
                    end
                end
            end
            StEmit: begin
                res_push = !bus.res_full;
                if (res_push) begin
                    row_idx_d = row_idx_q + ROW_BITS'(1);
                    state_d   = StLenReq;
                end
            end
            default: state_d = StLenReq;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLenReq;
            acc_q       <= '0;
            res_out_q   <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            row_idx_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            res_out_q   <= res_out_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            row_idx_q   <= row_idx_d;
            valid_q     <= mult_pop;
        end
    end

    // Strobes are gated by rst so they drop in the same cycle reset is raised.
    assign bus.mult_rd_en    = mult_pop && !rst;
    assign bus.row_len_rd_en = len_pop && !rst;
    assign bus.res_wr_en     = res_push && !rst;
    assign bus.busy          = (state_q != StLenReq) && !rst;
    assign bus.res_out       = res_out_q;
    assign bus.res_row       = row_idx_q;
endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: FIFO models plus a row-sum scoreboard checked every cycle.
module tb_row_accumulator;
    localparam int unsigned AB = 40;
    localparam int unsigned LB = 16;
    localparam int unsigned RB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    row_accumulator_if #(.MULT_BITS(32), .ACC_BITS(AB), .LEN_BITS(LB), .ROW_BITS(RB)) bus ();
    row_accumulator_if #(.MULT_BITS(8), .ACC_BITS(8), .LEN_BITS(LB), .ROW_BITS(RB)) bus8 ();

    row_accumulator #(.MULT_BITS(32), .ACC_BITS(AB), .LEN_BITS(LB), .ROW_BITS(RB)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    row_accumulator #(.MULT_BITS(8), .ACC_BITS(8), .LEN_BITS(LB), .ROW_BITS(RB)) u_dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int unsigned prod_q[$];
    int unsigned len_q[$];
    int unsigned prod8_q[$];
    int unsigned len8_q[$];
    logic [AB-1:0] exp_sum[64];
    int exp_len[64];
    int exp_lat[64];
    int n_exp = 0;
    int res_cnt = 0;
    int rows_done = 0;
    int pops_row = 0;
    int t_len = 0;
    logic in_row = 1'b0;
    logic starve = 1'b0;
    logic tog = 1'b0;
    logic [AB-1:0] last_res = '0;
    logic [RB-1:0] last_row = '0;
    int pops8 = 0;
    int got8 = 0;
    logic [7:0] res8 = '0;
    logic [AB-1:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Queue one row into the FIFO models and record its expected sum (mod 2^AB).
    task automatic add_row(input int unsigned len, input int unsigned p[8], input int lat);
        logic [63:0] s;
        s = '0;
        len_q.push_back(len);
        for (int i = 0; i < int'(len); i++) begin
            prod_q.push_back(p[i]);
            s = s + 64'(p[i]);
        end
        exp_sum[n_exp] = AB'(s);
        exp_len[n_exp] = int'(len);
        exp_lat[n_exp] = lat;
        n_exp++;
    endtask

    // One clock: compare outputs at negedge, then advance the FIFO models after posedge.
    task automatic step();
        logic pm, pl, pm8, pl8;
        @(negedge clk);
        pm  = bus.mult_rd_en;
        pl  = bus.row_len_rd_en;
        pm8 = bus8.mult_rd_en;
        pl8 = bus8.row_len_rd_en;
        if (rst) begin
            in_row    = 1'b0;
            rows_done = 0;
            pops_row  = 0;
        end else begin
            if (pm) begin
                chk("pop_when_mult_empty", 64'(bus.mult_empty), 64'(0));
                pops_row++;
            end
            if (pl) begin
                chk("len_pop_when_empty", 64'(bus.row_len_empty), 64'(0));
                chk("len_pop_mid_row", 64'(in_row), 64'(0));
                in_row   = 1'b1;
                pops_row = 0;
                t_len    = cyc;
            end
            if (bus.res_wr_en) begin
                chk("push_when_full", 64'(bus.res_full), 64'(0));
                if (res_cnt >= n_exp) begin
                    chk("unexpected_result", 64'(res_cnt), 64'(n_exp));
                end else begin
                    chk("res_out", 64'(bus.res_out), 64'(exp_sum[res_cnt]));
                    chk("res_row", 64'(bus.res_row), 64'(rows_done % 65536));
                    chk("row_pops", 64'(pops_row), 64'(exp_len[res_cnt]));
                    if (exp_lat[res_cnt] > 0) begin
                        chk("latency", 64'(cyc - t_len), 64'(exp_lat[res_cnt]));
                    end
                end
                last_res = bus.res_out;
                last_row = bus.res_row;
                res_cnt++;
                rows_done++;
                in_row = 1'b0;
            end
            if (pm8) pops8++;
            if (bus8.res_wr_en) begin
                got8++;
                res8 = bus8.res_out;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pm && prod_q.size() > 0) bus.mult_out = prod_q.pop_front();
        if (pl && len_q.size() > 0) bus.row_len = LB'(len_q.pop_front());
        if (pm8 && prod8_q.size() > 0) bus8.mult_out = 8'(prod8_q.pop_front());
        if (pl8 && len8_q.size() > 0) bus8.row_len = LB'(len8_q.pop_front());
        tog = ~tog;
        bus.mult_empty     = (prod_q.size() == 0) || (starve && tog);
        bus.row_len_empty  = (len_q.size() == 0);
        bus8.mult_empty    = (prod8_q.size() == 0);
        bus8.row_len_empty = (len8_q.size() == 0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (res_cnt < n_exp && k < budget) begin
            step();
            k++;
        end
        if (res_cnt < n_exp) chk("drain_timeout", 64'(res_cnt), 64'(n_exp));
        repeat (2) step();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_mult_rd_en"}, 64'(bus.mult_rd_en), 64'(0));
        chk({tag, "_row_len_rd_en"}, 64'(bus.row_len_rd_en), 64'(0));
        chk({tag, "_res_wr_en"}, 64'(bus.res_wr_en), 64'(0));
        chk({tag, "_res_out"}, 64'(bus.res_out), 64'(0));
        chk({tag, "_res_row"}, 64'(bus.res_row), 64'(0));
    endtask

    initial begin
        int k;
        rst                = 1'b1;
        bus.mult_out       = '0;
        bus.mult_empty     = 1'b1;
        bus.row_len        = '0;
        bus.row_len_empty  = 1'b1;
        bus.res_full       = 1'b0;
        bus8.mult_out      = '0;
        bus8.mult_empty    = 1'b1;
        bus8.row_len       = '0;
        bus8.row_len_empty = 1'b1;
        bus8.res_full      = 1'b0;
        #1;
        chk_outputs_zero("reset");
        step();
        step();
        rst = 1'b0;

        // Single row 2+5+7, result six cycles after the length pop.
        add_row(3, '{2, 5, 7, 0, 0, 0, 0, 0}, 6);
        drain(40);
        chk("t1_sum_literal", 64'(last_res), 64'(14));
        chk("t1_row_literal", 64'(last_row), 64'(0));

        // Zero-length row followed by a single-product row.
        add_row(0, '{0, 0, 0, 0, 0, 0, 0, 0}, 2);
        add_row(1, '{9, 0, 0, 0, 0, 0, 0, 0}, 4);
        drain(40);
        chk("t2_sum_literal", 64'(last_res), 64'(9));
        chk("t2_row_literal", 64'(last_row), 64'(2));

        // Product FIFO empty every other cycle.
        starve = 1'b1;
        add_row(4, '{1, 2, 3, 4, 0, 0, 0, 0}, 0);
        drain(60);
        starve = 1'b0;
        chk("t3_sum_literal", 64'(last_res), 64'(10));

        // Result FIFO full on entry to EMIT; next row length already waiting.
        bus.res_full = 1'b1;
        add_row(2, '{3, 4, 0, 0, 0, 0, 0, 0}, 0);
        add_row(1, '{8, 0, 0, 0, 0, 0, 0, 0}, 0);
        repeat (9) step();
        held = bus.res_out;
        chk("t4_held_literal", 64'(held), 64'(7));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stable_res_out", 64'(bus.res_out), 64'(held));
            chk("t4_no_push", 64'(bus.res_wr_en), 64'(0));
            chk("t4_no_len_pop", 64'(bus.row_len_rd_en), 64'(0));
            chk("t4_busy", 64'(bus.busy), 64'(1));
        end
        bus.res_full = 1'b0;
        drain(40);
        chk("t4_second_sum_literal", 64'(last_res), 64'(8));

        // Sum wider than 32 bits must be kept by the 40-bit accumulator.
        add_row(3, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 0, 0}, 0);
        drain(40);
        chk("t5_wide_literal", 64'(last_res), 64'h2_7FFF_FFFE);

        // 8-bit instance: 200 + 100 wraps to 44.
        len8_q.push_back(2);
        prod8_q.push_back(200);
        prod8_q.push_back(100);
        k = 0;
        while (got8 == 0 && k < 30) begin
            step();
            k++;
        end
        chk("t6_wrap_count", 64'(got8), 64'(1));
        chk("t6_wrap_literal", 64'(res8), 64'(44));
        chk("t6_wrap_pops", 64'(pops8), 64'(2));

        // Reset after two of four products are popped.
        add_row(4, '{5, 5, 5, 5, 0, 0, 0, 0}, 0);
        k = 0;
        while (!(in_row && pops_row == 2) && k < 30) begin
            step();
            k++;
        end
        chk("t7_reached_mid_row", 64'(pops_row), 64'(2));
        chk("t7_pre_reset_pop", 64'(bus.mult_rd_en), 64'(1));
        chk("t7_pre_reset_busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        #1;
        chk_outputs_zero("t7_in_reset");
        step();
        step();
        prod_q.delete();
        len_q.delete();
        n_exp = res_cnt;
        rst   = 1'b0;
        add_row(1, '{6, 0, 0, 0, 0, 0, 0, 0}, 4);
        drain(40);
        chk("t7_sum_literal", 64'(last_res), 64'(6));
        chk("t7_row_literal", 64'(last_row), 64'(0));

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
